// File: rtl/serial_pattern_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_pattern_scan_ctrl_if
// Command/result bundle between a command source (master) and the serial
// pattern scan controller (slave).
//
//   start        master -> slave  start request, honoured only while idle
//   abort        master -> slave  cancel a running scan, blocks start in idle
//   frame_in     master -> slave  FRAME_W-bit frame, scanned MSB first
//   pat_in       master -> slave  pattern, pat_in[pat_len-1] matched first
//   pat_len      master -> slave  pattern length (0 = never match)
//   busy         slave -> master  scan in progress
//   done         slave -> master  one-cycle pulse after a complete scan
//   det_pulse    slave -> master  combinational match strobe
//   match_count  slave -> master  matches in the last or current scan
//   first_pos    slave -> master  bit index (0 = MSB) ending the first match
//   found        slave -> master  at least one match seen
// ---------------------------------------------------------------------------
interface serial_pattern_scan_ctrl_if #(
   parameter int FRAME_W = 16,
   parameter int PAT_W   = 8
);
   localparam int LEN_W = $clog2(PAT_W + 1);
   localparam int CNT_W = $clog2(FRAME_W + 1);
   localparam int POS_W = $clog2(FRAME_W);

   logic               start;
   logic               abort;
   logic [FRAME_W-1:0] frame_in;
   logic [PAT_W-1:0]   pat_in;
   logic [LEN_W-1:0]   pat_len;
   logic               busy;
   logic               done;
   logic               det_pulse;
   logic [CNT_W-1:0]   match_count;
   logic [POS_W-1:0]   first_pos;
   logic               found;

   modport master (
      output start, abort, frame_in, pat_in, pat_len,
      input  busy, done, det_pulse, match_count, first_pos, found
   );

   modport slave (
      input  start, abort, frame_in, pat_in, pat_len,
      output busy, done, det_pulse, match_count, first_pos, found
   );
endinterface

// File: rtl/serial_pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// serial_pattern_scan_ctrl
// Loads a frame and a runtime pattern on start, then shifts the frame out
// MSB first, one bit per clock, through a non-overlapping exact-window Mealy
// matcher. Counts matches, records the first match position and pulses done
// after a complete scan.
//
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    slave side of serial_pattern_scan_ctrl_if (command in, results out)
// ---------------------------------------------------------------------------
module serial_pattern_scan_ctrl #(
   parameter int FRAME_W = 16,
   parameter int PAT_W   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   serial_pattern_scan_ctrl_if.slave   bus
);
   localparam int LEN_W = $clog2(PAT_W + 1);
   localparam int CNT_W = $clog2(FRAME_W + 1);
   localparam int POS_W = $clog2(FRAME_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t             state, state_nxt;

   logic [FRAME_W-1:0] frame_q;     // shifts left; MSB is the current bit
   logic [PAT_W-1:0]   pat_q;
   logic [LEN_W-1:0]   len_q;
   logic [PAT_W-1:0]   hist_q;      // previously consumed bits, newest in bit 0
   logic [LEN_W-1:0]   since_q;     // bits consumed since the last counted match
   logic [POS_W-1:0]   idx_q;
   logic [CNT_W-1:0]   count_q;
   logic [POS_W-1:0]   first_q;
   logic               found_q;

   logic               accept;
   logic               last_bit;
   logic               cur_bit;
   logic [PAT_W-1:0]   window;
   logic [PAT_W-1:0]   mask;
   logic               match;

   assign accept   = (state == S_IDLE) && bus.start && !bus.abort;
   assign last_bit = (idx_q == POS_W'(FRAME_W - 1));
   assign cur_bit  = frame_q[FRAME_W-1];

   // Window of the most recent PAT_W bits including the current one; only
   // the low len_q bits take part in the comparison.
   assign window = (hist_q << 1) | PAT_W'(cur_bit);

   // NOTE: every signal driven in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      mask = '0;
      for (int k = 0; k < PAT_W; k++) begin
         mask[k] = (k < int'(len_q));
      end
   end

   // The since-counter forbids a match until len_q fresh bits have been
   // consumed after the previous match, so matched bits are never reused and
   // cleared history can never fake a match at the start of the frame.
   assign match = (state == S_SHIFT) && (len_q != '0) &&
                  (((window ^ pat_q) & mask) == '0) &&
                  (({1'b0, since_q} + 1'b1) >= {1'b0, len_q});

   // -------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (accept) state_nxt = S_SHIFT;
         S_SHIFT: begin
            if (bus.abort)     state_nxt = S_IDLE;
            else if (last_bit) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------
   always_comb begin
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.det_pulse = 1'b0;
      unique case (state)
         S_SHIFT: begin
            bus.busy      = 1'b1;
            bus.det_pulse = match;
         end
         S_DONE:  bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.match_count = count_q;
   assign bus.first_pos   = first_q;
   assign bus.found       = found_q;

   // -------------------------------------------------------------------
   // Captured operands
   // -------------------------------------------------------------------
   // NOTE: frame, pattern and length are deliberately not reset: they are
   // always reloaded on the accept edge before the matcher looks at them.
   always_ff @(posedge clk) begin
      if (accept) begin
         frame_q <= bus.frame_in;
         pat_q   <= bus.pat_in;
         len_q   <= (bus.pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.pat_len;
      end else if (state == S_SHIFT) begin
         frame_q <= frame_q << 1;
      end
   end

   // -------------------------------------------------------------------
   // Matcher state and results
   // -------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q  <= '0;
         since_q <= '0;
         idx_q   <= '0;
         count_q <= '0;
         first_q <= '0;
         found_q <= 1'b0;
      end else if (accept) begin
         hist_q  <= '0;
         since_q <= '0;
         idx_q   <= '0;
         count_q <= '0;
         first_q <= '0;
         found_q <= 1'b0;
      end else if (state == S_SHIFT) begin
         // The current bit is evaluated even on an abort edge.
         hist_q <= window;
         idx_q  <= idx_q + 1'b1;
         if (match) begin
            since_q <= '0;
            count_q <= count_q + 1'b1;
            if (!found_q) begin
               first_q <= idx_q;
               found_q <= 1'b1;
            end
         end else if (since_q != LEN_W'(PAT_W)) begin
            since_q <= since_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_serial_pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_scan_ctrl
// Directed bench for serial_pattern_scan_ctrl. A reference model computes
// the expected per-bit strobes and final results for each scan; they are
// queued when the scan is started and popped when the DUT reports results.
// ---------------------------------------------------------------------------
module tb_serial_pattern_scan_ctrl;
   localparam int FRAME_W = 16;
   localparam int PAT_W   = 8;
   localparam int LEN_W   = $clog2(PAT_W + 1);
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam int POS_W   = $clog2(FRAME_W);

   typedef struct {
      logic [FRAME_W-1:0] det;     // det[i] = strobe expected while bit i is consumed
      logic [CNT_W-1:0]   count;
      logic [POS_W-1:0]   pos;
      logic               found;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   serial_pattern_scan_ctrl_if #(.FRAME_W(FRAME_W), .PAT_W(PAT_W)) bus ();

   serial_pattern_scan_ctrl #(.FRAME_W(FRAME_W), .PAT_W(PAT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference matcher: a match ending at bit i needs the last len bits to
   // equal the pattern and must not reach back into a previously counted match.
   function automatic exp_t model(input logic [FRAME_W-1:0] f, input logic [PAT_W-1:0] p,
                                  input int len_in, input int stop_i);
      exp_t e;
      int   len;
      int   last_end;
      bit   ok;
      e.det   = '0;
      e.count = '0;
      e.pos   = '0;
      e.found = 1'b0;
      len      = (len_in > PAT_W) ? PAT_W : len_in;
      last_end = -1;
      for (int i = 0; i < stop_i; i++) begin
         if (len > 0 && (i - last_end) >= len) begin
            ok = 1'b1;
            for (int k = 0; k < len; k++) begin
               if (f[FRAME_W-1-(i-k)] != p[k]) ok = 1'b0;
            end
            if (ok) begin
               e.det[i] = 1'b1;
               e.count  = e.count + 1'b1;
               if (!e.found) begin
                  e.pos   = POS_W'(i);
                  e.found = 1'b1;
               end
               last_end = i;
            end
         end
      end
      return e;
   endfunction

   task automatic pop_and_compare(input string tag);
      exp_t x;
      tests++;
      if (sb_q.size() == 0) begin
         fails++;
         $error("FAIL %s scoreboard: observed empty queue expected one entry", tag);
         return;
      end
      tests--;
      x = sb_q.pop_front();
      check({tag, " match_count"}, 32'(bus.match_count), 32'(x.count));
      check({tag, " first_pos"},   32'(bus.first_pos),   32'(x.pos));
      check({tag, " found"},       32'(bus.found),       32'(x.found));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"},        32'(bus.busy),        0);
      check({tag, " done"},        32'(bus.done),        0);
      check({tag, " det_pulse"},   32'(bus.det_pulse),   0);
      check({tag, " match_count"}, 32'(bus.match_count), 0);
      check({tag, " first_pos"},   32'(bus.first_pos),   0);
      check({tag, " found"},       32'(bus.found),       0);
   endtask

   // Runs one scan starting from a negedge in IDLE. abort_i / reset_i select
   // the bit index at which abort or reset is applied (-1 = never).
   task automatic scan(input string tag, input logic [FRAME_W-1:0] f,
                       input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] len,
                       input int abort_i, input int reset_i, input bit hold);
      exp_t e;
      int   stop_i;
      stop_i = (abort_i >= 0) ? abort_i + 1 : FRAME_W;
      e = model(f, p, int'(len), stop_i);
      if (reset_i < 0) sb_q.push_back(e);

      bus.frame_in = f;
      bus.pat_in   = p;
      bus.pat_len  = len;
      bus.start    = 1'b1;
      bus.abort    = 1'b0;
      @(posedge clk);                      // accept edge
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      bus.frame_in = ~f;                   // operands were captured; changes must not matter
      bus.pat_in   = ~p;
      bus.pat_len  = len + 1'b1;

      for (int i = 0; i < FRAME_W; i++) begin
         check($sformatf("%s busy[%0d]", tag, i), 32'(bus.busy), 1);
         check($sformatf("%s done_early[%0d]", tag, i), 32'(bus.done), 0);
         check($sformatf("%s det[%0d]", tag, i), 32'(bus.det_pulse), 32'(e.det[i]));
         if (i == abort_i) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            check({tag, " abort busy"}, 32'(bus.busy), 0);
            check({tag, " abort done"}, 32'(bus.done), 0);
            pop_and_compare({tag, " abort"});
            @(negedge clk);
            check({tag, " abort done_late"}, 32'(bus.done), 0);
            check({tag, " abort held count"}, 32'(bus.match_count), 32'(e.count));
            return;
         end
         if (i == reset_i) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_all_zero({tag, " reset"});
            return;
         end
         @(negedge clk);
      end

      // 17th edge counting the accept edge: DONE for exactly one cycle.
      check({tag, " done"},      32'(bus.done),      1);
      check({tag, " done busy"}, 32'(bus.busy),      0);
      check({tag, " done det"},  32'(bus.det_pulse), 0);
      pop_and_compare(tag);
      @(negedge clk);
      check({tag, " done_pulse"}, 32'(bus.done), 0);
      check({tag, " idle busy"},  32'(bus.busy), 0);
      check({tag, " held count"}, 32'(bus.match_count), 32'(e.count));
      check({tag, " held found"}, 32'(bus.found), 32'(e.found));
   endtask

   initial begin
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.frame_in = '0;
      bus.pat_in   = '0;
      bus.pat_len  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Non-overlapping: candidate ending at i=8 reuses bits of the i=4 match.
      scan("t1", 16'b1100_1100_1000_0000, 8'b0001_1001, 4'd5, -1, -1, 1'b0);
      check("t1 spec count", 32'(bus.match_count), 1);
      check("t1 spec pos",   32'(bus.first_pos),   4);

      scan("t2", 16'b1100_1110_0100_0000, 8'b0001_1001, 4'd5, -1, -1, 1'b0);
      check("t2 spec count", 32'(bus.match_count), 2);
      check("t2 spec pos",   32'(bus.first_pos),   4);

      scan("t3", 16'hFFFF, 8'h01, 4'd1, -1, -1, 1'b0);
      check("t3 spec count", 32'(bus.match_count), 16);
      check("t3 spec pos",   32'(bus.first_pos),   0);

      scan("t4", 16'b1100_1100_1000_0000, 8'b0001_1001, 4'd5, 6, -1, 1'b0);
      check("t4 spec count", 32'(bus.match_count), 1);
      scan("t4 rerun", 16'b1100_1100_1000_0000, 8'b0001_1001, 4'd5, -1, -1, 1'b0);
      check("t4 rerun count", 32'(bus.match_count), 1);

      scan("t5", 16'hA5C3, 8'h00, 4'd0, -1, -1, 1'b0);
      check("t5 spec count", 32'(bus.match_count), 0);
      check("t5 spec found", 32'(bus.found),       0);

      // Length above PAT_W is clamped to 8: ones-pattern matches at i=7 and i=15.
      scan("clamp", 16'hFFFF, 8'hFF, 4'd15, -1, -1, 1'b0);
      check("clamp count", 32'(bus.match_count), 2);
      check("clamp pos",   32'(bus.first_pos),   7);

      // abort together with start in IDLE blocks the start.
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      check("idle abort busy", 32'(bus.busy), 0);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      @(negedge clk);

      scan("t6 reset", 16'b1100_1110_0100_0000, 8'b0001_1001, 4'd5, -1, 8, 1'b0);

      // start held through DONE: the following IDLE start is the next accept.
      scan("t6 hold", 16'b1100_1100_1000_0000, 8'b0001_1001, 4'd5, -1, -1, 1'b1);
      scan("t6 next", 16'b1100_1110_0100_0000, 8'b0001_1001, 4'd5, -1, -1, 1'b0);
      check("t6 next count", 32'(bus.match_count), 2);

      check("scoreboard empty", 32'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
